pipe_hazard_sequencer: RTL and testbench

//  Parametrised pipeline stall/flush/bubble sequencer for the 5-stage MIPS core; sits between the hazard

---
 rtl/pipe_hazard_sequencer_pkg.sv | 29 ++
 rtl/pipe_hazard_sequencer_sat_counter.sv | 22 ++
 rtl/pipe_hazard_sequencer.sv | 110 +++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: stage bit positions,
// the registered FSM state encoding and the default stall/flush masks.
package pipe_ctrl_pkg;

    // Bit position of each pipeline register within the stall/flush vectors
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    localparam int DEF_NUM_STAGES = 5;

    // Load-use bubble holds PC and IF_ID while ID_EX receives a nop
    localparam logic [DEF_NUM_STAGES-1:0] DEF_LU_MASK =
        DEF_NUM_STAGES'((1 << STG_PC) | (1 << STG_IFID));

    // A taken branch squashes the wrong-path instruction sitting in IF_ID
    localparam logic [DEF_NUM_STAGES-1:0] DEF_FLUSH_MASK =
        DEF_NUM_STAGES'(1 << STG_IFID);

    // Registered sequencer state, visible on hz_state
    typedef enum logic [1:0] {
        HZ_IDLE      = 2'b00,
        HZ_LU_STALL  = 2'b01,
        HZ_MEM_STALL = 2'b10
    } hzState_t;

endpackage

// File: rtl/pipe_hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stick at MAX, return to zero on reset or clr
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline stall/flush/bubble sequencer: turns prioritised hazard requests
// into per-stage stall and flush vectors, tracks owed load-use bubbles across
// memory stalls, watches for stuck memory and counts stalled cycles.
module pipe_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int                    NUM_STAGES  = 5,
    parameter int                    LU_CYCLES   = 1,
    parameter logic [NUM_STAGES-1:0] LU_MASK     = NUM_STAGES'(DEF_LU_MASK),
    parameter logic [NUM_STAGES-1:0] FLUSH_MASK  = NUM_STAGES'(DEF_FLUSH_MASK),
    parameter int                    MEM_TIMEOUT = 16,
    parameter int                    PERF_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  ld_use_haz,
    input  logic                  br_taken,
    input  logic                  mem_wait,
    input  logic                  clr_perf,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  nop,
    output logic [1:0]            hz_state,
    output logic                  mem_timeout,
    output logic [PERF_W-1:0]     stall_cycles
);

    localparam int LU_REM_W  = $clog2(LU_CYCLES + 1);
    localparam int MEM_CNT_W = $clog2(MEM_TIMEOUT + 1);

    hzState_t              state;
    hzState_t              nextState;
    logic [LU_REM_W-1:0]   luRem;
    logic [LU_REM_W-1:0]   luRemNext;
    logic [MEM_CNT_W-1:0]  memCnt;

    assign hz_state = state;

    // State and owed-bubble register; reset returns to an idle pipe
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= HZ_IDLE;
            luRem <= '0;
        end else begin
            state <= nextState;
            luRem <= luRemNext;
        end
    end

    // Priority decode: memory freeze, owed bubble, branch flush, new load-use
    always_comb begin
        stall     = '0;
        flush     = '0;
        nop       = 1'b0;
        nextState = HZ_IDLE;
        luRemNext = luRem;
        if (Rst) begin
            luRemNext = '0;
        end else if (mem_wait) begin
            stall     = '1;
            nextState = HZ_MEM_STALL;
        end else if (luRem != '0) begin
            stall     = LU_MASK;
            nop       = 1'b1;
            luRemNext = luRem - LU_REM_W'(1);
            nextState = (luRemNext != '0) ? HZ_LU_STALL : HZ_IDLE;
        end else if (br_taken) begin
            flush     = FLUSH_MASK;
        end else if (ld_use_haz) begin
            stall     = LU_MASK;
            nop       = 1'b1;
            luRemNext = LU_REM_W'(LU_CYCLES - 1);
            nextState = (LU_CYCLES > 1) ? HZ_LU_STALL : HZ_IDLE;
        end
    end

    // Consecutive memory-wait cycles; any ready cycle restarts the count
    pipe_sat_counter #(
        .WIDTH (MEM_CNT_W),
        .MAX   (MEM_CNT_W'(MEM_TIMEOUT))
    ) u_memCnt (
        .clock (Clk),
        .reset (Rst),
        .inc   (mem_wait),
        .clr   (~mem_wait),
        .count (memCnt)
    );

    // Sticky watchdog: set when the wait run reaches the limit, cleared by reset only
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem_timeout <= 1'b0;
        end else if (mem_wait && (memCnt == MEM_CNT_W'(MEM_TIMEOUT - 1))) begin
            mem_timeout <= 1'b1;
        end
    end

    // Stalled-cycle performance counter
    pipe_sat_counter #(
        .WIDTH (PERF_W),
        .MAX   ({PERF_W{1'b1}})
    ) u_stallCycles (
        .clock (Clk),
        .reset (Rst),
        .inc   (|stall),
        .clr   (clr_perf),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Scoreboard bench for pipe_hazard_sequencer: directed scenarios followed by
// random traffic, each cycle predicted by a behavioural model of owed bubbles.
module tb_pipe_hazard_sequencer;

    localparam int NS       = 5;
    localparam int LUC      = 2;
    localparam int MTO      = 4;
    localparam int PW       = 4;
    localparam int PERF_MAX = (1 << PW) - 1;

    logic          clk;
    logic          rst;
    logic          ldUseHaz;
    logic          brTaken;
    logic          memWait;
    logic          clrPerf;
    logic [NS-1:0] stall;
    logic [NS-1:0] flush;
    logic          nop;
    logic [1:0]    hzState;
    logic          memTimeout;
    logic [PW-1:0] stallCycles;

    typedef struct {
        logic [NS-1:0] stall;
        logic [NS-1:0] flush;
        logic          nop;
        logic [1:0]    hz;
        logic          tmo;
        logic [PW-1:0] perf;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: bubbles still owed, length of current wait run,
    // watchdog flag, stall counter and what the last cycle was doing
    int   owed    = 0;
    int   memRun  = 0;
    bit   tmoFlag = 0;
    int   perf    = 0;
    int   lastSt  = 0;

    pipe_hazard_sequencer #(
        .NUM_STAGES  (NS),
        .LU_CYCLES   (LUC),
        .LU_MASK     (5'b00011),
        .FLUSH_MASK  (5'b00010),
        .MEM_TIMEOUT (MTO),
        .PERF_W      (PW)
    ) dut (
        .Clk          (clk),
        .Rst          (rst),
        .ld_use_haz   (ldUseHaz),
        .br_taken     (brTaken),
        .mem_wait     (memWait),
        .clr_perf     (clrPerf),
        .stall        (stall),
        .flush        (flush),
        .nop          (nop),
        .hz_state     (hzState),
        .mem_timeout  (memTimeout),
        .stall_cycles (stallCycles)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    // One cycle: drive inputs after the edge, predict, queue the prediction,
    // then advance the model past the coming edge
    task automatic applyStimulus(input bit r, input bit l, input bit b, input bit m, input bit c);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ldUseHaz = l; brTaken = b; memWait = m; clrPerf = c;

        e.stall = '0; e.flush = '0; e.nop = 1'b0;
        e.hz    = 2'(lastSt);
        e.tmo   = tmoFlag;
        e.perf  = PW'(perf);
        if (!r) begin
            if (m)             e.stall = 5'b11111;
            else if (owed > 0) begin e.stall = 5'b00011; e.nop = 1'b1; end
            else if (b)        e.flush = 5'b00010;
            else if (l)        begin e.stall = 5'b00011; e.nop = 1'b1; end
        end
        expQ.push_back(e);

        if (r) begin
            owed = 0; memRun = 0; tmoFlag = 0; perf = 0; lastSt = 0;
        end else begin
            if (m) begin
                memRun = (memRun < MTO) ? memRun + 1 : MTO;
                if (memRun == MTO) tmoFlag = 1;
                lastSt = 2;
            end else begin
                memRun = 0;
                if (owed > 0) begin
                    owed   = owed - 1;
                    lastSt = (owed > 0) ? 1 : 0;
                end else if (!b && l) begin
                    owed   = LUC - 1;
                    lastSt = (owed > 0) ? 1 : 0;
                end else begin
                    lastSt = 0;
                end
            end
            if (c)                 perf = 0;
            else if (e.stall != 0) perf = (perf < PERF_MAX) ? perf + 1 : PERF_MAX;
        end
    endtask

    // Monitor: every falling edge compares the DUT against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("stall",        16'(stall),       16'(e.stall));
                checkOutput("flush",        16'(flush),       16'(e.flush));
                checkOutput("nop",          16'(nop),         16'(e.nop));
                checkOutput("hz_state",     16'(hzState),     16'(e.hz));
                checkOutput("mem_timeout",  16'(memTimeout),  16'(e.tmo));
                checkOutput("stall_cycles", 16'(stallCycles), 16'(e.perf));
            end
        end
    end

    // Directed scenarios, then random traffic, then the summary
    initial begin
        rst = 1'b1; ldUseHaz = 1'b0; brTaken = 1'b0; memWait = 1'b0; clrPerf = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state held
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Single load-use gives a two-cycle bubble
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Branch wins over a simultaneous load-use; no bubble afterwards
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Load-use pre-empted by three memory-wait cycles, then resumed
        applyStimulus(0, 1, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Watchdog trips after four waits and stays set
        repeat (5) applyStimulus(0, 0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Stall counter saturates, then clear beats a same-cycle stall
        repeat (20) applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset in the middle of a memory stall
        repeat (2) applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 19) == 0));
        end

        repeat (2) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain got=%0d expected=0 pending predictions", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
